// File: rtl/q_frag_readback.sv
// Q_FRAG QZ readback: snapshots the flip-flop bank on request and
// streams it out one bit per valid/ready handshake.
module q_frag_readback #(
    parameter int    WIDTH = 8,
    parameter string MODE  = "LSB"
) (
    input  logic             QCK,
    input  logic             QRN,
    input  logic             QEN,
    input  logic [WIDTH-1:0] QZ_IN,
    input  logic             CAP_REQ,
    output logic             CAP_ACK,
    output logic             SO,
    output logic             SO_VALID,
    input  logic             SO_READY,
    output logic             SO_LAST,
    output logic             BUSY,
    output logic             OVR
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    idx;
    logic             cap_ack_q;
    logic             ovr_q;
    logic             shifting;

    generate
        if (MODE == "LSB") begin : g_lsb
            assign idx = cnt;
        end else if (MODE == "MSB") begin : g_msb
            assign idx = LAST - cnt;
        end else begin : g_bad_mode
            $error("q_frag_readback: MODE must be \"LSB\" or \"MSB\"");
            assign idx = cnt;
        end
    endgenerate

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("q_frag_readback: WIDTH must be in 2..64");
        end
    endgenerate

    // Outputs decode registered state only; no path from SO_READY/CAP_REQ.
    assign shifting = (state == SHIFT);
    assign SO_VALID = shifting;
    assign BUSY     = shifting;
    assign SO       = shifting & shadow[idx];
    assign SO_LAST  = shifting & (cnt == LAST);
    assign CAP_ACK  = cap_ack_q;
    assign OVR      = ovr_q;

    always_ff @(posedge QCK or negedge QRN) begin
        if (!QRN) begin
            state     <= IDLE;
            shadow    <= '0;
            cnt       <= '0;
            cap_ack_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else if (QEN) begin
            cap_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (CAP_REQ) begin
                        shadow    <= QZ_IN;
                        cnt       <= '0;
                        cap_ack_q <= 1'b1;
                        ovr_q     <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A request mid-frame is only flagged, never honoured.
                    if (CAP_REQ) ovr_q <= 1'b1;
                    if (SO_READY) begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q_frag_readback.sv
// Directed bench for q_frag_readback: one LSB-first and one MSB-first
// instance share stimulus; each test checks the relevant instance.
module tb_q_frag_readback;

    logic       QCK;
    logic       QRN;
    logic       QEN;
    logic [7:0] QZ_IN;
    logic       CAP_REQ;
    logic       SO_READY;

    logic l_ack, l_so, l_vld, l_last, l_busy, l_ovr;
    logic m_ack, m_so, m_vld, m_last, m_busy, m_ovr;

    int total = 0;
    int bad   = 0;
    int ack_cnt;

    q_frag_readback #(.WIDTH(8), .MODE("LSB")) u_lsb (
        .QCK(QCK), .QRN(QRN), .QEN(QEN), .QZ_IN(QZ_IN),
        .CAP_REQ(CAP_REQ), .CAP_ACK(l_ack), .SO(l_so),
        .SO_VALID(l_vld), .SO_READY(SO_READY), .SO_LAST(l_last),
        .BUSY(l_busy), .OVR(l_ovr)
    );

    q_frag_readback #(.WIDTH(8), .MODE("MSB")) u_msb (
        .QCK(QCK), .QRN(QRN), .QEN(QEN), .QZ_IN(QZ_IN),
        .CAP_REQ(CAP_REQ), .CAP_ACK(m_ack), .SO(m_so),
        .SO_VALID(m_vld), .SO_READY(SO_READY), .SO_LAST(m_last),
        .BUSY(m_busy), .OVR(m_ovr)
    );

    initial QCK = 1'b0;
    always #5 QCK = ~QCK;

    typedef struct {
        logic       cap;
        logic [7:0] qz;
        logic       so;
        logic       vld;
        logic       last;
        logic       ack;
        logic       busy;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    task automatic step(input logic qen, input logic cap,
                        input logic rdy, input logic [7:0] qz);
        QEN      = qen;
        CAP_REQ  = cap;
        SO_READY = rdy;
        QZ_IN    = qz;
        @(posedge QCK);
        #1;
        if (l_ack) ack_cnt++;
    endtask

    // Frame already captured (first bit showing); ready held high.
    task automatic expect_frame(input string tag, input logic [7:0] v,
                                input logic msb, input logic cap,
                                input logic [7:0] qz);
        for (int i = 0; i < 8; i++) begin
            int  idx;
            idx = msb ? 7 - i : i;
            chk($sformatf("%s so%0d", tag, i), msb ? m_so : l_so, v[idx]);
            chk($sformatf("%s vld%0d", tag, i), msb ? m_vld : l_vld, 1'b1);
            chk($sformatf("%s last%0d", tag, i), msb ? m_last : l_last,
                i == 7);
            step(1'b1, cap, 1'b1, qz);
        end
        chk({tag, " end vld"}, msb ? m_vld : l_vld, 1'b0);
        chk({tag, " end busy"}, msb ? m_busy : l_busy, 1'b0);
    endtask

    initial begin
        // A5 = 1010_0101, LSB first: 1,0,1,0,0,1,0,1
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        QRN = 1'b0; QEN = 1'b1; QZ_IN = 8'h00;
        CAP_REQ = 1'b0; SO_READY = 1'b0; ack_cnt = 0;
        #12;
        chk("rst ack", l_ack, 1'b0);
        chk("rst so", l_so, 1'b0);
        chk("rst vld", l_vld, 1'b0);
        chk("rst last", l_last, 1'b0);
        chk("rst busy", l_busy, 1'b0);
        chk("rst ovr", l_ovr, 1'b0);
        chk("rst m vld", m_vld, 1'b0);
        QRN = 1'b1;

        // Basic LSB frame
        ack_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, tbl[i].cap, 1'b1, tbl[i].qz);
            chk($sformatf("tbl%0d so", i), l_so, tbl[i].so);
            chk($sformatf("tbl%0d vld", i), l_vld, tbl[i].vld);
            chk($sformatf("tbl%0d last", i), l_last, tbl[i].last);
            chk($sformatf("tbl%0d ack", i), l_ack, tbl[i].ack);
            chk($sformatf("tbl%0d busy", i), l_busy, tbl[i].busy);
        end
        total++;
        if (ack_cnt != 1) begin
            bad++;
            $display("FAIL basic ack count got=%0d exp=1", ack_cnt);
        end

        // MSB with backpressure: C3 -> 1,1,0,0,0,0,1,1 over 16 cycles
        step(1'b1, 1'b1, 1'b0, 8'hC3);
        chk("msb ack", m_ack, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            v = 8'hC3;
            chk($sformatf("msb so%0d", i), m_so, v[7-i]);
            chk($sformatf("msb last%0d", i), m_last, i == 7);
            step(1'b1, 1'b0, 1'b0, 8'h00);
            chk($sformatf("msb hold so%0d", i), m_so, v[7-i]);
            chk($sformatf("msb hold vld%0d", i), m_vld, 1'b1);
            chk($sformatf("msb hold last%0d", i), m_last, i == 7);
            step(1'b1, 1'b0, 1'b1, 8'h00);
        end
        chk("msb end vld", m_vld, 1'b0);
        chk("msb end busy", m_busy, 1'b0);

        // QEN gating and overrun; 96 = 1001_0110 -> 0,1,1,0,1,0,0,1
        step(1'b1, 1'b1, 1'b1, 8'h96);
        chk("qen ack", l_ack, 1'b1);
        chk("qen so0", l_so, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("qen so1", l_so, 1'b1);
        chk("qen ack low", l_ack, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("qen so2", l_so, 1'b1);
        for (int j = 0; j < 3; j++) begin
            step(1'b0, j == 1, 1'b1, 8'h00);
            chk($sformatf("qen hold so%0d", j), l_so, 1'b1);
            chk($sformatf("qen hold vld%0d", j), l_vld, 1'b1);
            chk($sformatf("qen hold ovr%0d", j), l_ovr, 1'b0);
        end
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("qen so3", l_so, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        chk("ovr so4", l_so, 1'b1);
        chk("ovr set", l_ovr, 1'b1);
        chk("ovr no ack", l_ack, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("ovr so5", l_so, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("ovr so6", l_so, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("ovr so7", l_so, 1'b1);
        chk("ovr last7", l_last, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("ovr idle vld", l_vld, 1'b0);
        chk("ovr sticky", l_ovr, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'h3C);
        chk("ovr clr ack", l_ack, 1'b1);
        chk("ovr clr", l_ovr, 1'b0);
        expect_frame("cap3c", 8'h3C, 1'b0, 1'b0, 8'h00);

        // Snapshot isolation and back-to-back capture
        ack_cnt = 0;
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        chk("b2b ack1", l_ack, 1'b1);
        expect_frame("b2b ff", 8'hFF, 1'b0, 1'b1, 8'h00);
        chk("b2b idle ack", l_ack, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        chk("b2b ack2", l_ack, 1'b1);
        chk("b2b ovr clr", l_ovr, 1'b0);
        expect_frame("b2b 00", 8'h00, 1'b0, 1'b0, 8'hFF);
        total++;
        if (ack_cnt != 2) begin
            bad++;
            $display("FAIL b2b ack count got=%0d exp=2", ack_cnt);
        end

        // Mid-frame asynchronous reset; 33 -> 1,1,0,0,1,1,0,0
        step(1'b1, 1'b1, 1'b1, 8'h33);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("rst pre vld", l_vld, 1'b1);
        chk("rst pre so3", l_so, 1'b0);
        #3;
        QRN = 1'b0;
        #1;
        chk("arst vld", l_vld, 1'b0);
        chk("arst busy", l_busy, 1'b0);
        chk("arst ack", l_ack, 1'b0);
        chk("arst m vld", m_vld, 1'b0);
        #2;
        QRN = 1'b1;
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("post rst idle", l_vld, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h5A);
        chk("post rst ack", l_ack, 1'b1);
        expect_frame("post 5a", 8'h5A, 1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
